gpr_wr_arbiter: RTL and testbench
=================================

Name: gpr_wr_arbiter

Overview:
Shares the single write port of the 32 x 64-bit general-purpose register file among NREQ writeback requesters (e.g. ALU writeback, load unit, debug/host poke).
- Arbitrates round-robin or fixed-priority; one write is committed per cycle.
- Registers the winning write into the register-file write port.
- Keeps a pending-write scoreboard, so issue logic can stall on hazards without reading the register file.

Parameters:
NREQ, 3, number of write requesters (2..8)
FIXED_PRIO, 0, 1 = lowest index always wins; 0 = round-robin
XLEN, 64, data width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester write request
req_ready  output  NREQ  per-requester grant/accept
req_rd  input  NREQ*5  destination index, requester i at bits [5i+4:5i]
req_data  input  NREQ*XLEN  write data, requester i at [XLEN*i+XLEN-1:XLEN*i]
rf_wen  output  1  register-file write enable
rf_waddr  output  5  register-file write index
rf_wdata  output  XLEN  register-file write data
grant_id  output  3  index of the last accepted requester
sb_set_valid  input  1  issue stage reserves a destination
sb_set_rd  input  5  index being reserved
sb_flush  input  1  clear all busy bits (pipeline flush)
busy  output  32  pending-write bitmap; busy[0] is constant 0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0.
  - busy=0; round-robin pointer=0.
  - Reset mid-transfer drops the in-flight write with no commit.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid, rd and data stable until accepted.
  - req_ready is combinational from req_valid and the pointer, and is one-hot or zero.
  - The register file never backpressures, so some valid requester is granted every cycle.
- Arbitration:
  - FIXED_PRIO=1: lowest valid index wins.
  - FIXED_PRIO=0: search starts at the pointer and wraps modulo NREQ. On a grant, the pointer becomes (winner+1) mod NREQ; with no grant, the pointer holds.
- Latency:
  - The write accepted at edge N appears on rf_wen/rf_waddr/rf_wdata during cycle N+1; the register file samples it at edge N+1.
  - rf_wen=0 in any cycle following an edge with no accepted request.
  - grant_id updates on every accepted transfer.
- x0 writes: accepted normally (ready asserted, pointer advances), but the following cycle has rf_wen=0 and busy is unaffected.
- Scoreboard:
  - Edge with sb_set_valid && sb_set_rd!=0: the set_rd bit is set.
  - Edge with an accepted transfer of rd!=0: the rd bit is cleared.
  - Same rd set and cleared on one edge: set wins (a new producer supersedes).
  - sb_flush: all bits cleared; it overrides a simultaneous set.
  - sb_flush does not cancel an accepted write or the write already registered on the rf_w* port.
- Back-to-back writes to the same rd from different requesters are committed in grant order; the last one wins in the register file.

Optional Feature:
GPR_WR_TRACE_EN
- Defined: the block imports the DPI-C function gpr_wr_trace(input int idx, input longint data). It calls the function on every clk edge where rf_wen=1, with rf_waddr and rf_wdata, for difftest/trace logging.
- Undefined: no DPI import and no simulation-only code; the block is fully synthesizable.

Decomposition:
- Package gpr_pkg:
  - GPR_NUM=32, GPR_AW=5, XLEN=64.
  - typedef gpr_idx_t (logic [4:0]) and xlen_t (logic [63:0]).
  - The register file and the DPI register-export logic use the same package.
- One sub-module, gpr_rr_arb: a parameterized NREQ round-robin / fixed-priority picker. It takes valid and the pointer, returns the one-hot grant and the encoded index, and owns the pointer register.

Test Plan:
- Single write: req_valid=001, rd=5, data=0xDEAD_BEEF -> ready=001 the same cycle; next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF; grant_id=0.
- Round-robin: all 3 requesters held valid for 6 cycles -> grants 0,1,2,0,1,2; FIXED_PRIO=1 rerun -> grant 0 every cycle, requesters 1 and 2 starved.
- x0 write: requester 1 with rd=0 -> ready asserted; next cycle rf_wen=0; busy unchanged; pointer advances to 2.
- Scoreboard: reserve rd=7 -> busy[7]=1; a same-edge accepted write to rd=7 plus a new reserve of 7 -> busy[7] stays 1; a later write to 7 -> busy[7]=0. Reserve rd=0 -> busy[0]=0.
- Flush: busy=0x0000_00F0, sb_flush with sb_set_valid rd=9 -> busy=0; the write accepted that edge still appears on rf_wen next cycle.
- Reset mid-op: assert rst_n=0 asynchronously with a write pending on rf_w* -> rf_wen drops immediately, busy=0, pointer=0; after release, the first grant goes to the lowest valid requester.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file, its write-port
// arbiter and the register-export logic.
package gpr_pkg;

  localparam int GPR_NUM = 32;
  localparam int GPR_AW  = 5;
  localparam int XLEN    = 64;
  localparam int REQ_IW  = 3;

  typedef logic [GPR_AW-1:0] gpr_idx_t;
  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [REQ_IW-1:0] req_idx_t;

endpackage

// File: rtl/gpr_rr_arb.sv
// NREQ-way round-robin / fixed-priority picker. Owns the rotating pointer and
// returns a one-hot grant plus its encoded index.
module gpr_rr_arb
  import gpr_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output req_idx_t        grant_idx,
  output logic            grant_any
);

  req_idx_t   ptr_q, ptr_d;
  logic [7:0] valid_ext;
  logic [3:0] cand;
  logic       found;

  // Walk NREQ candidates starting at the pointer (or at 0 in fixed mode),
  // wrapping modulo NREQ; the first valid candidate wins.
  always_comb begin
    valid_ext = 8'(valid);
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ((FIXED_PRIO != 0) ? 4'd0 : {1'b0, ptr_q}) + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (!found && valid_ext[cand[2:0]]) begin
        found     = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  assign grant     = found ? (NREQ'(1) << grant_idx) : '0;
  assign grant_any = found;

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (grant_idx == req_idx_t'(NREQ - 1)) ? '0 : grant_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gpr_wr_arbiter.sv
// Shares the GPR write port among NREQ writeback requesters and keeps a
// pending-write scoreboard.
module gpr_wr_arbiter #(
  parameter int NREQ       = 3,
  parameter int FIXED_PRIO = 0,
  parameter int XLEN       = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [2:0]           grant_id,
  input  logic                 sb_set_valid,
  input  logic [4:0]           sb_set_rd,
  input  logic                 sb_flush,
  output logic [31:0]          busy
);

  import gpr_pkg::*;

  logic [NREQ-1:0]    grant;
  req_idx_t           grant_idx;
  logic               grant_any;
  gpr_idx_t           sel_rd;
  logic [XLEN-1:0]    sel_data;

  logic               rf_wen_q, rf_wen_d;
  gpr_idx_t           rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  req_idx_t           grant_id_q, grant_id_d;
  logic [GPR_NUM-1:0] busy_q, busy_d;

  gpr_rr_arb #(
    .NREQ       (NREQ),
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // One-hot AND-OR select of the winning requester's payload.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // x0 writes are accepted but never reach the register file.
  always_comb begin
    rf_wen_d   = grant_any && (sel_rd != '0);
    rf_waddr_d = grant_any ? sel_rd : rf_waddr_q;
    rf_wdata_d = grant_any ? sel_data : rf_wdata_q;
    grant_id_d = grant_any ? grant_idx : grant_id_q;
  end

  // Clear, then set (new producer supersedes), then flush overrides all.
  always_comb begin
    busy_d = busy_q;
    if (grant_any && (sel_rd != '0)) begin
      busy_d[sel_rd] = 1'b0;
    end
    if (sb_set_valid && (sb_set_rd != '0)) begin
      busy_d[sb_set_rd] = 1'b1;
    end
    if (sb_flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Directed bench for gpr_wr_arbiter: stimulus pushes expected register-file
// writes into a queue, a negedge monitor pops and compares each committed write.
module tb_gpr_wr_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 rf_wen;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [2:0]           grant_id;
  logic                 sb_set_valid;
  logic [4:0]           sb_set_rd;
  logic                 sb_flush;
  logic [31:0]          busy;

  logic [NREQ-1:0]      fp_ready;
  logic                 fp_wen;
  logic [4:0]           fp_waddr;
  logic [XLEN-1:0]      fp_wdata;
  logic [2:0]           fp_grant_id;
  logic [31:0]          fp_busy;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  gpr_wr_arbiter #(.NREQ(NREQ), .FIXED_PRIO(0), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .grant_id     (grant_id),
    .sb_set_valid (sb_set_valid),
    .sb_set_rd    (sb_set_rd),
    .sb_flush     (sb_flush),
    .busy         (busy)
  );

  gpr_wr_arbiter #(.NREQ(NREQ), .FIXED_PRIO(1), .XLEN(XLEN)) dut_fp (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (fp_ready),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .rf_wen       (fp_wen),
    .rf_waddr     (fp_waddr),
    .rf_wdata     (fp_wdata),
    .grant_id     (fp_grant_id),
    .sb_set_valid (sb_set_valid),
    .sb_set_rd    (sb_set_rd),
    .sb_flush     (sb_flush),
    .busy         (fp_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    req_rd[5*i +: 5]         = rd;
    req_data[XLEN*i +: XLEN] = d;
  endtask

  // One cycle of stimulus: drive at negedge, check ready before the edge,
  // check grant_id after it. exp_w < 0 means no grant is expected.
  task automatic xfer(input string tag, input logic [2:0] vld, input int exp_w,
                      input logic set_v, input logic [4:0] set_rd, input logic flush,
                      input bit chk_fp);
    logic [2:0] er;
    wr_t        w;
    @(negedge clk);
    req_valid    = vld;
    sb_set_valid = set_v;
    sb_set_rd    = set_rd;
    sb_flush     = flush;
    er = (exp_w < 0) ? 3'b000 : (3'b001 << exp_w);
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(er));
    if (chk_fp) chk({tag, "_fp_ready"}, 64'(fp_ready), 64'(vld[0] ? 3'b001 : 3'b000));
    if (exp_w >= 0) begin
      w.rd   = req_rd[5*exp_w +: 5];
      w.data = req_data[XLEN*exp_w +: XLEN];
      if (w.rd != 5'd0) exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
    if (exp_w >= 0) chk({tag, "_grant_id"}, 64'(grant_id), 64'(exp_w));
    if (chk_fp) chk({tag, "_fp_grant_id"}, 64'(fp_grant_id), 64'd0);
    req_valid    = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
    sb_flush     = 1'b0;
  endtask

  // Scoreboard monitor: every committed write must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rf_write: unexpected write x%0d = %h, expected none", rf_waddr, rf_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        $display("write x%0d = %h (expected x%0d = %h)", rf_waddr, rf_wdata, w.rd, w.data);
        chk("rf_waddr", 64'(rf_waddr), 64'(w.rd));
        chk("rf_wdata", rf_wdata, w.data);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_rd       = '0;
    req_data     = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
    sb_flush     = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Round-robin with all three requesters valid; fixed-priority twin always picks 0.
    set_req(0, 5'd10, 64'hA000_0000_0000_0000);
    set_req(1, 5'd11, 64'hA111_1111_1111_1111);
    set_req(2, 5'd12, 64'hA222_2222_2222_2222);
    for (int c = 0; c < 6; c++) begin
      xfer("rr", 3'b111, c % 3, 1'b0, 5'd0, 1'b0, 1'b1);
    end

    // Single write from requester 0.
    set_req(0, 5'd5, 64'h0000_0000_DEAD_BEEF);
    xfer("single", 3'b001, 0, 1'b0, 5'd0, 1'b0, 1'b0);

    // x0 write from requester 1: accepted, no commit, busy unchanged.
    set_req(1, 5'd0, 64'h0000_0000_0000_1234);
    xfer("x0", 3'b010, 1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("x0_busy", 64'(busy), 64'd0);

    // Pointer advanced to 2, so requester 2 wins with all valid.
    set_req(0, 5'd1, 64'h0000_0000_0000_0001);
    set_req(1, 5'd2, 64'h0000_0000_0000_0002);
    set_req(2, 5'd3, 64'h0000_0000_0000_0003);
    xfer("ptr2", 3'b111, 2, 1'b0, 5'd0, 1'b0, 1'b0);

    // Scoreboard set / clear / set-wins.
    xfer("res7", 3'b000, -1, 1'b1, 5'd7, 1'b0, 1'b0);
    chk("res7_busy", 64'(busy), 64'h80);
    set_req(0, 5'd7, 64'h7777_0000_0000_0001);
    xfer("setwin", 3'b001, 0, 1'b1, 5'd7, 1'b0, 1'b0);
    chk("setwin_busy", 64'(busy), 64'h80);
    set_req(1, 5'd7, 64'h7777_0000_0000_0002);
    xfer("clr7", 3'b010, 1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("clr7_busy", 64'(busy), 64'h0);
    xfer("res0", 3'b000, -1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("res0_busy", 64'(busy), 64'h0);

    // Build busy = 0xF0, then flush with a simultaneous reserve and accepted write.
    for (int r = 4; r < 8; r++) begin
      xfer("resf", 3'b000, -1, 1'b1, 5'(r), 1'b0, 1'b0);
    end
    chk("pre_flush_busy", 64'(busy), 64'hF0);
    set_req(2, 5'd20, 64'hF1F1_F1F1_0000_0014);
    xfer("flush", 3'b100, 2, 1'b1, 5'd9, 1'b1, 1'b0);
    chk("flush_busy", 64'(busy), 64'h0);

    // Asynchronous reset while a write sits on the rf_w* port: it must be dropped.
    @(negedge clk);
    set_req(1, 5'd3, 64'hBAD0_BAD0_BAD0_BAD0);
    req_valid    = 3'b010;
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd3;
    #1;
    chk("rstmid_ready", 64'(req_ready), 64'b010);
    @(posedge clk);
    #1;
    req_valid    = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
    chk("rstmid_pending_wen", 64'(rf_wen), 64'd1);
    chk("rstmid_busy_before", 64'(busy), 64'h8);
    chk("rstmid_grant_before", 64'(grant_id), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wen", 64'(rf_wen), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_grant_id", 64'(grant_id), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pointer back at 0: lowest valid requester wins.
    set_req(1, 5'd8, 64'h0000_0000_0000_0808);
    set_req(2, 5'd9, 64'h0000_0000_0000_0909);
    xfer("postrst", 3'b110, 1, 1'b0, 5'd0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
